// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: state encodings,
// instruction size, default reset vector and the target alignment helper.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_REDIR_WAIT = 2'd2,
    ST_HALTED     = 2'd3
  } state_e;

  localparam int unsigned INST_BYTES        = 4;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_npc_sel.sv
// Combinational next-PC mux for the fetch sequencer; also flags a wrong-path
// accept (flush_o). Optional feature macro: RUN_TRACE_EN (BOOT pre-increments pc).
module pc_sequencer_npc_sel
  import pc_sequencer_pkg::*;
(
  input  state_e      state_i,
  input  logic [31:0] pc_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic [31:0] pend_target_i,
  input  logic        accept_i,
  input  logic        halt_i,
  output logic [31:0] npc_o,
  output logic        flush_o
);

  logic [31:0] seq_pc;

  // 32-bit modulo increment: the top word of the address space wraps to 0.
  assign seq_pc = pc_i + 32'(INST_BYTES);

  always_comb begin
    npc_o   = pc_i;
    flush_o = 1'b0;
    unique case (state_i)
      ST_BOOT: begin
`ifdef RUN_TRACE_EN
        npc_o = seq_pc;
`else
        npc_o = pc_i;
`endif
      end
      ST_RUN: begin
        if (halt_i) begin
          npc_o = pc_i;
        end else if (redirect_valid_i && accept_i) begin
          npc_o   = align_pc(redirect_target_i);
          flush_o = 1'b1;
        end else if (!redirect_valid_i && accept_i) begin
          npc_o = seq_pc;
        end
      end
      ST_REDIR_WAIT: begin
        // The buffered (older) redirect wins over anything arriving now.
        if (!halt_i && accept_i) begin
          npc_o   = pend_target_i;
          flush_o = 1'b1;
        end
      end
      default: npc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, handshakes with the IROM, buffers late
// redirects and freezes on halt. Optional feature macro: RUN_TRACE_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall_if,
  input  logic        halt_req,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush_if,
  output logic        halted
);

`ifdef RUN_TRACE_EN
  localparam logic [31:0] PC_RST = RESET_VEC - 32'(INST_BYTES);
`else
  localparam logic [31:0] PC_RST = RESET_VEC;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        accept;

  assign fetch_valid = (state_q == ST_RUN) || (state_q == ST_REDIR_WAIT);
  assign halted      = (state_q == ST_HALTED);
  assign accept      = fetch_valid && fetch_ready && !stall_if;
  assign pc          = pc_q;

  pc_sequencer_npc_sel u_npc_sel (
    .state_i           (state_q),
    .pc_i              (pc_q),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .pend_target_i     (pend_q),
    .accept_i          (accept),
    .halt_i            (halt_req),
    .npc_o             (pc_d),
    .flush_o           (flush_if)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALTED;
          pend_d  = '0;
        end else if (redirect_valid && !accept) begin
          state_d = ST_REDIR_WAIT;
          pend_d  = align_pc(redirect_target);
        end
      end
      ST_REDIR_WAIT: begin
        if (halt_req) begin
          state_d = ST_HALTED;
          pend_d  = '0;
        end else if (accept) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= PC_RST;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// checked every cycle against a flag-based behavioural model of the fetch rules.
module tb_pc_sequencer;

`ifdef RUN_TRACE_EN
  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam bit          TRACE  = 1'b1;
`else
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam bit          TRACE  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        stall_if = 1'b0;
  logic        halt_req = 1'b0;
  logic        fetch_ready = 1'b0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush_if;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.RESET_VEC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall_if        (stall_if),
    .halt_req        (halt_req),
    .fetch_ready     (fetch_ready),
    .pc              (pc),
    .fetch_valid     (fetch_valid),
    .flush_if        (flush_if),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  // Behavioural model: booting / halted / pending-redirect flags plus a pc value.
  logic        m_boot, m_halted, m_pend_v;
  logic [31:0] m_pc, m_pend;

  always @(posedge clk or posedge rst) begin : model
    logic acc;
    if (rst) begin
      m_boot   <= 1'b1;
      m_halted <= 1'b0;
      m_pend_v <= 1'b0;
      m_pend   <= '0;
      m_pc     <= RST_PC;
    end else begin
      acc = !m_boot && !m_halted && fetch_ready && !stall_if;
      if (m_halted) begin
        m_halted <= 1'b1;
      end else if (m_boot) begin
        m_boot <= 1'b0;
        if (TRACE) m_pc <= m_pc + 32'd4;
      end else if (halt_req) begin
        m_halted <= 1'b1;
        m_pend_v <= 1'b0;
      end else if (m_pend_v) begin
        if (acc) begin
          m_pc     <= m_pend;
          m_pend_v <= 1'b0;
        end
      end else if (redirect_valid) begin
        if (acc) m_pc <= redirect_target & ~32'h3;
        else begin
          m_pend   <= redirect_target & ~32'h3;
          m_pend_v <= 1'b1;
        end
      end else if (acc) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic e_fv, e_acc, e_fl;
    e_fv  = !m_boot && !m_halted;
    e_acc = e_fv && fetch_ready && !stall_if;
    e_fl  = e_acc && !halt_req && (m_pend_v || redirect_valid);
    n_tests++;
    if (pc !== m_pc || fetch_valid !== e_fv || flush_if !== e_fl || halted !== m_halted) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got pc=%h fv=%b fl=%b h=%b, want pc=%h fv=%b fl=%b h=%b",
               $time, pc, fetch_valid, flush_if, halted, m_pc, e_fv, e_fl, m_halted);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] addr);
    redirect_valid  = 1'b1;
    redirect_target = addr;
    fetch_ready     = 1'b1;
    stall_if        = 1'b0;
    halt_req        = 1'b0;
    step();
    redirect_valid  = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    fetch_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (pc !== RST_PC || fetch_valid !== 1'b0 || halted !== 1'b0 || flush_if !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_vals got pc=%h fv=%b h=%b fl=%b want pc=%h 0 0 0",
                 pc, fetch_valid, halted, flush_if, RST_PC);
      end
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (fetch_valid !== 1'b0 || pc !== RST_PC) begin
      n_fail++;
      $display("FAIL boot_cycle got fv=%b pc=%h want fv=0 pc=%h", fetch_valid, pc, RST_PC);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      n_tests++;
      if (pc !== 32'(i * 4) || fetch_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL boot_seq[%0d] got pc=%h fv=%b want pc=%h fv=1", i, pc, fetch_valid, 32'(i * 4));
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    for (int mode = 0; mode < 2; mode++) begin
      go_to(32'h10);
      fetch_ready = (mode == 0) ? 1'b0 : 1'b1;
      stall_if    = (mode == 0) ? 1'b0 : 1'b1;
      repeat (3) begin
        @(negedge clk);
        n_tests++;
        if (pc !== 32'h10 || fetch_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold[m%0d] got pc=%h fv=%b want pc=10 fv=1", mode, pc, fetch_valid);
        end
        step();
      end
      fetch_ready = 1'b1;
      stall_if    = 1'b0;
      step();
      @(negedge clk);
      n_tests++;
      if (pc !== 32'h14) begin
        n_fail++;
        $display("FAIL bp_release[m%0d] got pc=%h want pc=14", mode, pc);
      end
      step();
    end
  endtask

  task automatic test_redirect_accept();
    go_to(32'h20);
    redirect_valid  = 1'b1;
    redirect_target = 32'h103;
    @(negedge clk);
    n_tests++;
    if (flush_if !== 1'b1 || pc !== 32'h20) begin
      n_fail++;
      $display("FAIL redir_flush got fl=%b pc=%h want fl=1 pc=20", flush_if, pc);
    end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (pc !== 32'h100 || flush_if !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_target got pc=%h fl=%b want pc=100 fl=0", pc, flush_if);
    end
    step();
  endtask

  task automatic test_buffered_redirect();
    go_to(32'h40);
    fetch_ready     = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    @(negedge clk);
    n_tests++;
    if (flush_if !== 1'b0 || pc !== 32'h40) begin
      n_fail++;
      $display("FAIL buf_latch got fl=%b pc=%h want fl=0 pc=40", flush_if, pc);
    end
    step();
    redirect_target = 32'h300;
    @(negedge clk);
    n_tests++;
    if (pc !== 32'h40 || fetch_valid !== 1'b1 || flush_if !== 1'b0) begin
      n_fail++;
      $display("FAIL buf_wait got pc=%h fv=%b fl=%b want pc=40 fv=1 fl=0", pc, fetch_valid, flush_if);
    end
    step();
    redirect_valid = 1'b0;
    fetch_ready    = 1'b1;
    @(negedge clk);
    n_tests++;
    if (pc !== 32'h40 || flush_if !== 1'b1) begin
      n_fail++;
      $display("FAIL buf_accept got pc=%h fl=%b want pc=40 fl=1", pc, flush_if);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (pc !== 32'h200 || flush_if !== 1'b0) begin
      n_fail++;
      $display("FAIL buf_target got pc=%h fl=%b want pc=200 fl=0", pc, flush_if);
    end
    step();
  endtask

  task automatic test_wrap();
    go_to(32'hFFFF_FFFF);
    @(negedge clk);
    n_tests++;
    if (pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_mask got pc=%h want pc=fffffffc", pc);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_zero got pc=%h want pc=00000000", pc);
    end
    step();
  endtask

  task automatic test_halt();
    go_to(32'h80);
    halt_req        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h500;
    @(negedge clk);
    n_tests++;
    if (flush_if !== 1'b0 || pc !== 32'h80) begin
      n_fail++;
      $display("FAIL halt_cycle got fl=%b pc=%h want fl=0 pc=80", flush_if, pc);
    end
    step();
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_ready     = 1'($urandom_range(0, 1));
      stall_if        = 1'($urandom_range(0, 1));
      redirect_valid  = 1'($urandom_range(0, 1));
      redirect_target = $urandom;
      halt_req        = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 32'h80) begin
        n_fail++;
        $display("FAIL halt_hold[%0d] got h=%b fv=%b pc=%h want h=1 fv=0 pc=80", i, halted, fetch_valid, pc);
      end
      step();
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    fetch_ready    = 1'b1;
    stall_if       = 1'b0;
    rst            = 1'b1;
    @(negedge clk);
    n_tests++;
    if (halted !== 1'b0 || fetch_valid !== 1'b0 || pc !== RST_PC) begin
      n_fail++;
      $display("FAIL halt_rst got h=%b fv=%b pc=%h want h=0 fv=0 pc=%h", halted, fetch_valid, pc, RST_PC);
    end
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    n_tests++;
    if (fetch_valid !== 1'b1 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL halt_recover got fv=%b pc=%h want fv=1 pc=0", fetch_valid, pc);
    end
    step();
  endtask

  task automatic test_reset_mid();
    fetch_ready = 1'b1;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (pc !== RST_PC || fetch_valid !== 1'b0 || flush_if !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst got pc=%h fv=%b fl=%b h=%b want pc=%h 0 0 0",
               pc, fetch_valid, flush_if, halted, RST_PC);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic        hold_p;
    logic [31:0] pc_p;
    hold_p = 1'b0;
    pc_p   = '0;
    for (int i = 0; i < 400; i++) begin
      fetch_ready     = ($urandom_range(0, 3) != 0);
      stall_if        = ($urandom_range(0, 4) == 0);
      redirect_valid  = ($urandom_range(0, 3) == 0);
      redirect_target = $urandom;
      halt_req        = ($urandom_range(0, 63) == 0);
      if ((halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) rst = 1'b1;
      @(negedge clk);
      if (hold_p && !rst) begin
        n_tests++;
        if (pc !== pc_p) begin
          n_fail++;
          $display("FAIL rand_stable[%0d] got pc=%h want pc=%h", i, pc, pc_p);
        end
      end
      hold_p = fetch_valid && !(fetch_ready && !stall_if) && !rst;
      pc_p   = pc;
      step();
      rst = 1'b0;
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_accept();
    test_buffered_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
